sseg_scan_reader: RTL and testbench

- Reads back a multiplexed 4-digit seven-segment display bus.
- The bus carries a one-hot digit select plus a 7-bit segment pattern (bit6=a … bit0=g, active-high). The block decodes each digit's pattern back to a hex nibble.
- A value is published only after it has been seen unchanged for several complete scan frames.
- Used for loop-back checking of the display path and for reading values off external display-driven instruments.

---
 rtl/sseg_scan_reader.sv | 190 +++++++++++++++++++
 tb/tb_sseg_scan_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_reader.sv
// sseg_scan_reader: reads back a multiplexed seven-segment display bus,
// decodes each digit to a hex nibble and publishes the full value only once
// it has been seen unchanged for STABLE_FRAMES complete, error-free frames.
// Optional build macro SSEG_READER_BLANK_EN: when defined, a blanked digit
// (pattern 0000000, leading-zero suppression) is legal and reads back as 0.
module sseg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int SETTLE        = 2,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS-1:0]   an,
    input  logic [6:0]          sseg_in,
    output logic [4*DIGITS-1:0] value,
    output logic                value_valid,
    output logic                locked,
    output logic                err
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_FRAMES);

    typedef enum logic [2:0] {
        S_WAIT_SEL,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD,
        S_COMMIT
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [DIGITS-1:0]   an_s1;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_s1;
    logic [6:0]          seg_q;

    logic [3:0]          settle_cnt;
    logic [DIGITS-1:0]   sel;
    logic [4*DIGITS-1:0] frame_buf;
    logic [4*DIGITS-1:0] prev_buf;
    logic [DIGITS-1:0]   seen;
    logic                bad;
    logic [3:0]          stable_cnt;

    logic                dec_ok;
    logic [3:0]          dec_nib;
    logic                seen_hit;
    logic [DIGITS-1:0]   seen_cap;
    logic                bad_cap;
    logic [3:0]          stable_next;
    logic                publish;

    // Map a segment pattern (a..g, active-high) to {legal, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
`ifdef SSEG_READER_BLANK_EN
            7'b0000000: r = {1'b1, 4'h0};
`endif
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Two-flop synchronisers: the display bus is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '0;
            an_q   <= '0;
            seg_s1 <= '0;
            seg_q  <= '0;
        end else begin
            an_s1  <= an;
            an_q   <= an_s1;
            seg_s1 <= sseg_in;
            seg_q  <= seg_s1;
        end
    end

    // Decode, frame-restart detection and the stable-count/publish decision.
    always_comb begin
        {dec_ok, dec_nib} = decode_seg(seg_q);
        seen_hit = |(seen & sel);
        seen_cap = (seen_hit ? '0 : seen) | sel;
        bad_cap  = (seen_hit ? 1'b0 : bad) | ~dec_ok;
        if (bad) begin
            stable_next = 4'd0;
        end else if (frame_buf == prev_buf) begin
            stable_next = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
        end else begin
            stable_next = 4'd1;
        end
        publish = !bad && (stable_next == STABLE_MAX) && (!locked || frame_buf != value);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT_SEL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one capture per select dwell, commit when all digits seen.
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_SEL: if ($onehot(an_q)) state_next = S_SETTLE;
            S_SETTLE: begin
                if (an_q != sel) begin
                    state_next = S_WAIT_SEL;
                end else if (settle_cnt <= 4'd1) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE:  state_next = (&seen_cap) ? S_COMMIT : S_HOLD;
            S_HOLD:     if (an_q != sel) state_next = S_WAIT_SEL;
            S_COMMIT:   state_next = S_HOLD;
            default:    state_next = S_WAIT_SEL;
        endcase
    end

    // Frame assembly, stability tracking and the published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= '0;
            sel         <= '0;
            frame_buf   <= '0;
            prev_buf    <= '0;
            seen        <= '0;
            bad         <= 1'b0;
            stable_cnt  <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                S_WAIT_SEL: begin
                    if ($onehot(an_q)) begin
                        settle_cnt <= SETTLE_LOAD;
                        sel        <= an_q;
                    end
                end
                S_SETTLE: settle_cnt <= settle_cnt - 4'd1;
                S_CAPTURE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (sel[i]) frame_buf[i*4 +: 4] <= dec_nib;
                    end
                    seen <= seen_cap;
                    bad  <= bad_cap;
                end
                S_COMMIT: begin
                    stable_cnt <= stable_next;
                    err        <= bad;
                    if (!bad) prev_buf <= frame_buf;
                    if (publish) begin
                        value       <= frame_buf;
                        value_valid <= 1'b1;
                        locked      <= 1'b1;
                    end
                    seen <= '0;
                    bad  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sseg_scan_reader.sv
// tb_sseg_scan_reader: directed display scans checked against a frame-level
// model of the reader (queue of expected publish/error events), plus literal
// expectations at the end of each scenario.
module tb_sseg_scan_reader;
    localparam int SF = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'b0000;
    logic [6:0]  sseg_in = 7'b0000000;
    logic [15:0] value;
    logic        value_valid;
    logic        locked;
    logic        err;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_err = 0;

    // Segment patterns indexed by hex digit.
    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Frame-level model state.
    bit          m_seen [4];
    int          m_nib [4];
    bit          m_bad;
    int          m_stable;
    logic [15:0] m_prev;
    logic [15:0] m_value;
    bit          m_locked;
    // Expected events: bit16=1 means err pulse, else publish of bits 15:0.
    logic [16:0] exp_q [$];
    logic [16:0] ev;
    logic [15:0] shadow_value;
    bit          shadow_locked;

    sseg_scan_reader #(
        .DIGITS(4),
        .SETTLE(2),
        .STABLE_FRAMES(SF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .an(an),
        .sseg_in(sseg_in),
        .value(value),
        .value_valid(value_valid),
        .locked(locked),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == p) return i;
        end
`ifdef SSEG_READER_BLANK_EN
        if (p == 7'b0000000) return 0;
`endif
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_seen[i] = 1'b0;
            m_nib[i]  = 0;
        end
        m_bad = 1'b0;
        m_stable = 0;
        m_prev = 16'h0;
        m_value = 16'h0;
        m_locked = 1'b0;
        exp_q.delete();
        shadow_value = 16'h0;
        shadow_locked = 1'b0;
    endfunction

    function automatic void model_commit();
        logic [15:0] frame;
        frame = 16'(m_nib[3] * 4096 + m_nib[2] * 256 + m_nib[1] * 16 + m_nib[0]);
        if (m_bad) begin
            exp_q.push_back({1'b1, 16'h0});
            m_stable = 0;
        end else begin
            if (frame == m_prev) m_stable = (m_stable + 1 > SF) ? SF : m_stable + 1;
            else m_stable = 1;
            m_prev = frame;
            if (m_stable == SF && (!m_locked || frame != m_value)) begin
                exp_q.push_back({1'b0, frame});
                m_value = frame;
                m_locked = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        m_bad = 1'b0;
    endfunction

    // Digit k is captured with pattern p (long dwell).
    function automatic void model_capture(input int k, input logic [6:0] p);
        int n;
        bit all;
        n = model_decode(p);
        if (m_seen[k]) begin
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
            m_bad = 1'b0;
        end
        m_seen[k] = 1'b1;
        m_nib[k] = (n < 0) ? 0 : n;
        if (n < 0) m_bad = 1'b1;
        all = 1'b1;
        for (int i = 0; i < 4; i++) if (!m_seen[i]) all = 1'b0;
        if (all) model_commit();
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
        an = a;
        sseg_in = s;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic showDigit(input int k, input logic [6:0] p);
        model_capture(k, p);
        applyStimulus(4'(1 << k), p, 8);
    endtask

    task automatic showFrame(input logic [15:0] v);
        for (int k = 0; k < 4; k++) showDigit(k, seg_tab[v[k*4 +: 4]]);
    endtask

    task automatic drain(input string name);
        an = 4'b0000;
        sseg_in = 7'b0000000;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic pulseReset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_value", value, 16'h0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_valid", value_valid, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Per-cycle compare of pulses, value and locked against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (value_valid) n_valid++;
            if (err) n_err++;
            if (value_valid || err) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", {value_valid, err}, 2'b00);
                end else begin
                    ev = exp_q.pop_front();
                    checkOutput("pulse_kind", {value_valid, err}, ev[16] ? 2'b01 : 2'b10);
                    if (!ev[16]) begin
                        checkOutput("published_value", value, ev[15:0]);
                        shadow_value = ev[15:0];
                        shadow_locked = 1'b1;
                    end
                end
            end
            checkOutput("value_track", value, shadow_value);
            checkOutput("locked_track", locked, shadow_locked);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_value", value, 16'h0);
        checkOutput("init_locked", locked, 0);
        checkOutput("init_valid", value_valid, 0);
        checkOutput("init_err", err, 0);
        rst_n = 1'b1;

        // Steady 1234 scan: one publish on frame 3, silence afterwards.
        n_valid = 0;
        for (int f = 0; f < 10; f++) begin
            showFrame(16'h1234);
            if (f == 1) checkOutput("steady_unlocked_after_2", locked, 0);
        end
        drain("steady");
        checkOutput("steady_pulses", n_valid, 1);
        checkOutput("steady_value", value, 16'h1234);
        checkOutput("steady_locked", locked, 1);

        // Change to ABCD: old value held until the 3rd new frame.
        n_valid = 0;
        for (int f = 0; f < 4; f++) begin
            showFrame(16'hABCD);
            if (f == 1) checkOutput("change_hold_old", value, 16'h1234);
        end
        drain("change");
        checkOutput("change_pulses", n_valid, 1);
        checkOutput("change_value", value, 16'hABCD);

        // Back to 1234, then a frame with an illegal digit2 while locked.
        for (int f = 0; f < 3; f++) showFrame(16'h1234);
        drain("relock");
        checkOutput("relock_value", value, 16'h1234);
        n_valid = 0;
        n_err = 0;
        showDigit(0, seg_tab[4]);
        showDigit(1, seg_tab[3]);
        showDigit(2, 7'b1010101);
        showDigit(3, seg_tab[1]);
        for (int f = 0; f < 3; f++) showFrame(16'h1234);
        drain("badframe");
        checkOutput("badframe_err_pulses", n_err, 1);
        checkOutput("badframe_valid_pulses", n_valid, 0);
        checkOutput("badframe_value", value, 16'h1234);

        // Glitches: multi-hot select and a too-short dwell carrying a bad pattern.
        n_valid = 0;
        n_err = 0;
        showDigit(0, seg_tab[4]);
        showDigit(1, seg_tab[3]);
        applyStimulus(4'b0110, 7'b1010101, 5);
        applyStimulus(4'b0100, 7'b1010101, 2);
        applyStimulus(4'b0000, 7'b0000000, 3);
        showDigit(2, seg_tab[2]);
        showDigit(3, seg_tab[1]);
        drain("glitch");
        checkOutput("glitch_err_pulses", n_err, 0);
        checkOutput("glitch_valid_pulses", n_valid, 0);

        // Digit1 repeated before digit3: the frame restarts.
        n_valid = 0;
        n_err = 0;
        showDigit(0, seg_tab[8]);
        showDigit(1, seg_tab[7]);
        showDigit(2, seg_tab[6]);
        showDigit(1, seg_tab[7]);
        showDigit(3, seg_tab[5]);
        showDigit(0, seg_tab[8]);
        showDigit(2, seg_tab[6]);
        showFrame(16'h5678);
        checkOutput("restart_hold_old", value, 16'h1234);
        showFrame(16'h5678);
        drain("restart");
        checkOutput("restart_pulses", n_valid, 1);
        checkOutput("restart_value", value, 16'h5678);

        // Reset in mid-frame, then three fresh frames are needed.
        showDigit(0, seg_tab[0]);
        showDigit(1, seg_tab[15]);
        pulseReset();
        n_valid = 0;
        showFrame(16'h9EF0);
        showFrame(16'h9EF0);
        checkOutput("postrst_unlocked", locked, 0);
        checkOutput("postrst_value_zero", value, 16'h0);
        showFrame(16'h9EF0);
        drain("postrst");
        checkOutput("postrst_pulses", n_valid, 1);
        checkOutput("postrst_value", value, 16'h9EF0);
        checkOutput("postrst_locked", locked, 1);

        // Blanked digit3 with digits 0,0,7.
        pulseReset();
        n_valid = 0;
        n_err = 0;
        for (int f = 0; f < 5; f++) begin
            showDigit(0, seg_tab[7]);
            showDigit(1, seg_tab[0]);
            showDigit(2, seg_tab[0]);
            showDigit(3, 7'b0000000);
        end
        drain("blank");
`ifdef SSEG_READER_BLANK_EN
        checkOutput("blank_pulses", n_valid, 1);
        checkOutput("blank_err_pulses", n_err, 0);
        checkOutput("blank_value", value, 16'h0007);
        checkOutput("blank_locked", locked, 1);
`else
        checkOutput("blank_pulses", n_valid, 0);
        checkOutput("blank_err_pulses", n_err, 5);
        checkOutput("blank_locked", locked, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
